alu_operand_stage: RTL

//  ID/EX segment register and operand supplier for the ALU. Latches decoded fields at
//  the D->E edge, then drives Operand1/Operand2/AluContrl into the ALU. Resolves RAW

---
 rtl/alu_operand_stage_if.sv | 60 ++++++
 rtl/alu_operand_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : D-stage, forwarding and E-stage signal bundle for alu_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) ();
  logic                 stall_e;
  logic                 flush_e;
  logic                 valid_d;
  logic [3:0]           alu_ctrl_d;
  logic [XLEN-1:0]      reg1_d;
  logic [XLEN-1:0]      reg2_d;
  logic [XLEN-1:0]      imm_d;
  logic [XLEN-1:0]      pc_d;
  logic [RF_ADDR_W-1:0] rs1_d;
  logic [RF_ADDR_W-1:0] rs2_d;
  logic [RF_ADDR_W-1:0] rd_d;
  logic                 reg_write_d;
  logic                 mem_read_d;
  logic                 op1_src_d;
  logic [1:0]           op2_src_d;
  logic                 reg_write_m;
  logic [RF_ADDR_W-1:0] rd_m;
  logic [XLEN-1:0]      result_m;
  logic                 reg_write_w;
  logic [RF_ADDR_W-1:0] rd_w;
  logic [XLEN-1:0]      result_w;
  logic [XLEN-1:0]      Operand1;
  logic [XLEN-1:0]      Operand2;
  logic [3:0]           AluContrl;
  logic [XLEN-1:0]      store_data_e;
  logic                 valid_e;
  logic [RF_ADDR_W-1:0] rd_e;
  logic                 reg_write_e;
  logic                 mem_read_e;
  logic                 load_use_haz;
  logic [1:0]           fwd1_sel;
  logic [1:0]           fwd2_sel;

  modport master (
    output stall_e, flush_e, valid_d, alu_ctrl_d, reg1_d, reg2_d, imm_d, pc_d,
           rs1_d, rs2_d, rd_d, reg_write_d, mem_read_d, op1_src_d, op2_src_d,
           reg_write_m, rd_m, result_m, reg_write_w, rd_w, result_w,
    input  Operand1, Operand2, AluContrl, store_data_e, valid_e, rd_e,
           reg_write_e, mem_read_e, load_use_haz, fwd1_sel, fwd2_sel
  );

  modport slave (
    input  stall_e, flush_e, valid_d, alu_ctrl_d, reg1_d, reg2_d, imm_d, pc_d,
           rs1_d, rs2_d, rd_d, reg_write_d, mem_read_d, op1_src_d, op2_src_d,
           reg_write_m, rd_m, result_m, reg_write_w, rd_w, result_w,
    output Operand1, Operand2, AluContrl, store_data_e, valid_e, rd_e,
           reg_write_e, mem_read_e, load_use_haz, fwd1_sel, fwd2_sel
  );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : ID/EX register with MEM/WB operand forwarding and load-use detect.
//               Forwarding is built only when OPERAND_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int         XLEN      = 32,
  parameter int         RF_ADDR_W = 5,
  parameter logic [3:0] ALU_ADD   = 4'd3
) (
  input  logic              clk,
  input  logic              rst,
  alu_operand_stage_if.slave bus_io
);

  typedef struct packed {
    logic                 valid;
    logic [3:0]           alu;
    logic [XLEN-1:0]      reg1;
    logic [XLEN-1:0]      reg2;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [RF_ADDR_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 op1_src;
    logic [1:0]           op2_src;
  } e_stage_t;

  e_stage_t        stage_q;
  e_stage_t        stage_d;
  e_stage_t        w_nop;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [1:0]      w_fwd1_sel;
  logic [1:0]      w_fwd2_sel;
  logic [XLEN-1:0] w_op2;

  always_comb begin
    w_nop     = '0;
    w_nop.alu = ALU_ADD;
  end

  always_comb begin
    stage_d = stage_q;
    if (bus_io.flush_e) begin
      stage_d = w_nop;
    end else if (!bus_io.stall_e) begin
      stage_d.valid     = bus_io.valid_d;
      stage_d.alu       = bus_io.alu_ctrl_d;
      stage_d.reg1      = bus_io.reg1_d;
      stage_d.reg2      = bus_io.reg2_d;
      stage_d.imm       = bus_io.imm_d;
      stage_d.pc        = bus_io.pc_d;
      stage_d.rs1       = bus_io.rs1_d;
      stage_d.rs2       = bus_io.rs2_d;
      stage_d.rd        = bus_io.rd_d;
      stage_d.reg_write = bus_io.reg_write_d;
      stage_d.mem_read  = bus_io.mem_read_d;
      stage_d.op1_src   = bus_io.op1_src_d;
      stage_d.op2_src   = bus_io.op2_src_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= w_nop;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef OPERAND_FWD_EN
  // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    w_fwd1_sel = 2'b00;
    w_rs1_val  = stage_q.reg1;
    if (bus_io.reg_write_m && (bus_io.rd_m != '0) && (bus_io.rd_m == stage_q.rs1)) begin
      w_fwd1_sel = 2'b10;
      w_rs1_val  = bus_io.result_m;
    end else if (bus_io.reg_write_w && (bus_io.rd_w != '0) && (bus_io.rd_w == stage_q.rs1)) begin
      w_fwd1_sel = 2'b01;
      w_rs1_val  = bus_io.result_w;
    end
  end

  always_comb begin
    w_fwd2_sel = 2'b00;
    w_rs2_val  = stage_q.reg2;
    if (bus_io.reg_write_m && (bus_io.rd_m != '0) && (bus_io.rd_m == stage_q.rs2)) begin
      w_fwd2_sel = 2'b10;
      w_rs2_val  = bus_io.result_m;
    end else if (bus_io.reg_write_w && (bus_io.rd_w != '0) && (bus_io.rd_w == stage_q.rs2)) begin
      w_fwd2_sel = 2'b01;
      w_rs2_val  = bus_io.result_w;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus_io.reg_write_m, bus_io.rd_m, bus_io.result_m,
                          bus_io.reg_write_w, bus_io.rd_w, bus_io.result_w,
                          stage_q.rs1, stage_q.rs2};
  assign w_fwd1_sel   = 2'b00;
  assign w_fwd2_sel   = 2'b00;
  assign w_rs1_val    = stage_q.reg1;
  assign w_rs2_val    = stage_q.reg2;
`endif

  always_comb begin
    case (stage_q.op2_src)
      2'b00:   w_op2 = w_rs2_val;
      2'b01:   w_op2 = stage_q.imm;
      2'b10:   w_op2 = XLEN'(4);
      default: w_op2 = '0;
    endcase
  end

  assign bus_io.Operand1     = stage_q.op1_src ? stage_q.pc : w_rs1_val;
  assign bus_io.Operand2     = w_op2;
  assign bus_io.AluContrl    = stage_q.alu;
  assign bus_io.store_data_e = w_rs2_val;
  assign bus_io.valid_e      = stage_q.valid;
  assign bus_io.rd_e         = stage_q.rd;
  assign bus_io.reg_write_e  = stage_q.reg_write;
  assign bus_io.mem_read_e   = stage_q.mem_read;
  assign bus_io.fwd1_sel     = w_fwd1_sel;
  assign bus_io.fwd2_sel     = w_fwd2_sel;

  assign bus_io.load_use_haz = !rst && stage_q.mem_read && stage_q.valid &&
                               (stage_q.rd != '0) &&
                               ((stage_q.rd == bus_io.rs1_d) || (stage_q.rd == bus_io.rs2_d));

endmodule
`default_nettype wire
